// File: rtl/alarm_scheduler_if.sv
// Slot-programming bus of the alarm scheduler: write strobe, target slot,
// BCD alarm time and per-slot enable, with the reject pulse back to the host.
interface alarm_scheduler_if #(parameter int IDX_W = 2);
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_h1, wr_h0, wr_m1, wr_m0;
  logic             wr_slot_en;
  logic             wr_err;

  modport master (output wr_en, wr_idx, wr_h1, wr_h0, wr_m1, wr_m0, wr_slot_en,
                  input  wr_err);
  modport slave  (input  wr_en, wr_idx, wr_h1, wr_h0, wr_m1, wr_m0, wr_slot_en,
                  output wr_err);
endinterface

// File: rtl/alarm_scheduler.sv
// Multi-slot HH:MM alarm controller with ring / snooze / stop sequencing,
// all timing derived from the one-cycle tick_1s enable.
module alarm_scheduler #(
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 15,
  parameter int SNOOZE_SECS = 30,
  parameter int MAX_SNOOZE  = 3,
  parameter int IDX_W       = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick_1s,
  input  logic [3:0]          cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0,
  input  logic                al_on,
  input  logic                stop_btn,
  input  logic                snooze_btn,
  alarm_scheduler_if.slave    wr,
  output logic                alarm,
  output logic [IDX_W-1:0]    active_idx,
  output logic                snooze_active,
  output logic [1:0]          snooze_cnt
);
  typedef struct packed {
    logic       en;
    logic [3:0] h1, h0, m1, m0;
  } slot_t;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  slot_t            slot_q [NUM_ALARMS];
  slot_t            slot_d [NUM_ALARMS];
  state_t           state_q, state_d;
  logic [10:0]      cnt_q, cnt_d;
  logic [1:0]       snz_cnt_q, snz_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             alarm_q, alarm_d;
  logic             snz_act_q, snz_act_d;
  logic             wr_err_q, wr_err_d;
  logic [1:0]       btn_q, btn_d, btn_prev_q, btn_prev_d;  // [1]=stop, [0]=snooze

  logic                  wr_bad, match, stop_edge, snz_edge;
  logic [NUM_ALARMS-1:0] hit;
  logic [IDX_W-1:0]      hit_idx;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_cmp
    assign hit[g] = slot_q[g].en && slot_q[g].h1 == cur_h1 && slot_q[g].h0 == cur_h0 &&
                    slot_q[g].m1 == cur_m1 && slot_q[g].m0 == cur_m0;
  end

  assign match     = tick_1s && cur_s1 == 4'd0 && cur_s0 == 4'd0 && al_on && |hit;
  assign stop_edge = btn_q[1] & ~btn_prev_q[1];
  assign snz_edge  = btn_q[0] & ~btn_prev_q[0];

  // Descending scan so the lowest matching slot is the last assignment.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (hit[i]) hit_idx = IDX_W'(i);
  end

  always_comb begin
    wr_bad = (int'(wr.wr_idx) >= NUM_ALARMS) || wr.wr_h1 > 4'd2 || wr.wr_h0 > 4'd9 ||
             wr.wr_m1 > 4'd5 || wr.wr_m0 > 4'd9 || (wr.wr_h1 == 4'd2 && wr.wr_h0 > 4'd3);
    wr_err_d = wr.wr_en && wr_bad;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      slot_d[i] = slot_q[i];
      if (wr.wr_en && !wr_bad && int'(wr.wr_idx) == i)
        slot_d[i] = '{en: wr.wr_slot_en, h1: wr.wr_h1, h0: wr.wr_h0, m1: wr.wr_m1, m0: wr.wr_m0};
    end
    btn_d      = {stop_btn, snooze_btn};
    btn_prev_d = btn_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snz_cnt_d = snz_cnt_q;
    idx_d     = idx_q;
    if (!al_on) begin
      state_d   = IDLE;
      snz_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (match) begin
          state_d   = RINGING;
          cnt_d     = 11'(RING_SECS);
          idx_d     = hit_idx;
          snz_cnt_d = '0;
        end
        RINGING: begin
          if (stop_edge) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
          end else if (snz_edge && int'(snz_cnt_q) < MAX_SNOOZE) begin
            state_d   = SNOOZED;
            cnt_d     = 11'(SNOOZE_SECS);
            snz_cnt_d = snz_cnt_q + 2'd1;
          end else if (match) begin
            cnt_d = 11'(RING_SECS);
            idx_d = hit_idx;
          end else if (tick_1s) begin
            if (cnt_q == 11'd1) state_d = IDLE;
            else                cnt_d   = cnt_q - 11'd1;
          end
        end
        SNOOZED: begin
          if (stop_edge) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
          end else if (match) begin
            // A fresh alarm event preempts the snooze and restarts the snooze budget.
            state_d   = RINGING;
            cnt_d     = 11'(RING_SECS);
            idx_d     = hit_idx;
            snz_cnt_d = '0;
          end else if (tick_1s) begin
            if (cnt_q == 11'd1) begin
              state_d = RINGING;
              cnt_d   = 11'(RING_SECS);
            end else begin
              cnt_d = cnt_q - 11'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    alarm_d   = (state_d == RINGING);
    snz_act_d = (state_d == SNOOZED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      snz_cnt_q  <= '0;
      idx_q      <= '0;
      alarm_q    <= 1'b0;
      snz_act_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      btn_q      <= '0;
      btn_prev_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      idx_q      <= idx_d;
      alarm_q    <= alarm_d;
      snz_act_q  <= snz_act_d;
      wr_err_q   <= wr_err_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign alarm         = alarm_q;
  assign active_idx    = idx_q;
  assign snooze_active = snz_act_q;
  assign snooze_cnt    = snz_cnt_q;
  assign wr.wr_err     = wr_err_q;
endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: stimulus queues expected output events
// (with the tick number they must occur on), a monitor pops them as they appear.
module tb_alarm_scheduler;
  localparam int IW = 3;

  logic clk = 1'b0, reset_n = 1'b0, tick_1s = 1'b0;
  logic [3:0] cur_h1 = '0, cur_h0 = '0, cur_m1 = '0, cur_m0 = '0, cur_s1 = '0, cur_s0 = '0;
  logic al_on = 1'b1, stop_btn = 1'b0, snooze_btn = 1'b0;
  logic alarm, snooze_active;
  logic [IW-1:0] active_idx;
  logic [1:0] snooze_cnt;

  alarm_scheduler_if #(.IDX_W(IW)) wif ();

  alarm_scheduler #(.NUM_ALARMS(4), .RING_SECS(15), .SNOOZE_SECS(30), .MAX_SNOOZE(3), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .cur_s1(cur_s1), .cur_s0(cur_s0), .al_on(al_on),
    .stop_btn(stop_btn), .snooze_btn(snooze_btn), .wr(wif),
    .alarm(alarm), .active_idx(active_idx), .snooze_active(snooze_active), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          a, sa, we;
    logic [1:0]    sc;
    logic [IW-1:0] idx;
    int            tk;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0, n_fail = 0, tick_cnt = 0;
  bit  mon_en = 1'b0;

  task automatic mon_loop();
    ev_t o, e, prev;
    int  n_ev = 0;
    prev = '{a: 1'b0, sa: 1'b0, we: 1'b0, sc: 2'd0, idx: '0, tk: 0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        o = '{a: alarm, sa: snooze_active, we: wif.wr_err, sc: snooze_cnt, idx: active_idx, tk: tick_cnt};
        if (o.we || o.a !== prev.a || o.sa !== prev.sa || o.sc !== prev.sc || o.idx !== prev.idx) begin
          n_tests++;
          n_ev++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ev%0d unexpected: a=%0b sa=%0b sc=%0d idx=%0d we=%0b tick=%0d",
                     n_ev, o.a, o.sa, o.sc, o.idx, o.we, o.tk);
          end else begin
            e = exp_q.pop_front();
            if (o.a !== e.a || o.sa !== e.sa || o.sc !== e.sc || o.idx !== e.idx || o.we !== e.we || o.tk != e.tk) begin
              n_fail++;
              $display("FAIL ev%0d got a=%0b sa=%0b sc=%0d idx=%0d we=%0b tick=%0d, want a=%0b sa=%0b sc=%0d idx=%0d we=%0b tick=%0d",
                       n_ev, o.a, o.sa, o.sc, o.idx, o.we, o.tk, e.a, e.sa, e.sc, e.idx, e.we, e.tk);
            end
          end
        end
        prev = o;
      end
    end
  endtask

  task automatic expect_ev(input logic a, sa, input logic [1:0] sc, input logic [IW-1:0] idx,
                           input logic we, input int tk);
    exp_q.push_back('{a: a, sa: sa, we: we, sc: sc, idx: idx, tk: tk});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_at(input logic [3:0] h1, h0, m1, m0);
    cur_h1 = h1; cur_h0 = h0; cur_m1 = m1; cur_m0 = m0; cur_s1 = 4'd0; cur_s0 = 4'd0;
    tick_1s = 1'b1;
    tick_cnt++;
    cyc();
    tick_1s = 1'b0;
    cyc();
  endtask

  // Off-minute ticks (seconds = 01) never match any slot.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cur_s0 = 4'd1;
      tick_1s = 1'b1;
      tick_cnt++;
      cyc();
      tick_1s = 1'b0;
      cyc();
    end
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic [3:0] h1, h0, m1, m0, input logic en);
    wif.wr_idx = idx; wif.wr_h1 = h1; wif.wr_h0 = h0; wif.wr_m1 = m1; wif.wr_m0 = m0;
    wif.wr_slot_en = en;
    wif.wr_en = 1'b1;
    cyc();
    wif.wr_en = 1'b0;
    cyc();
  endtask

  task automatic press(input logic stop, snz);
    stop_btn = stop;
    snooze_btn = snz;
    repeat (3) cyc();
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    fork
      mon_loop();
    join_none
    wif.wr_en = 1'b0; wif.wr_idx = '0; wif.wr_slot_en = 1'b0;
    wif.wr_h1 = '0; wif.wr_h0 = '0; wif.wr_m1 = '0; wif.wr_m0 = '0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    chk("reset_alarm", 32'(alarm), 0);
    chk("reset_idx", 32'(active_idx), 0);
    chk("reset_snz_act", 32'(snooze_active), 0);
    chk("reset_snz_cnt", 32'(snooze_cnt), 0);
    chk("reset_wr_err", 32'(wif.wr_err), 0);
    mon_en = 1'b1;

    // Slot 2 = 07:30: rings on the match tick, drops 15 ticks later.
    wr(3'd2, 4'd0, 4'd7, 4'd3, 4'd0, 1'b1);
    expect_ev(1, 0, 2'd0, 3'd2, 0, tick_cnt + 1);
    expect_ev(0, 0, 2'd0, 3'd2, 0, tick_cnt + 16);
    tick_at(4'd0, 4'd7, 4'd3, 4'd0);
    tick_n(17);

    // Rejected writes must pulse wr_err and leave slot 0 at 06:15.
    wr(3'd0, 4'd0, 4'd6, 4'd1, 4'd5, 1'b1);
    expect_ev(0, 0, 2'd0, 3'd2, 1, tick_cnt); wr(3'd0, 4'd2, 4'd4, 4'd0, 4'd0, 1'b1);
    expect_ev(0, 0, 2'd0, 3'd2, 1, tick_cnt); wr(3'd5, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    expect_ev(0, 0, 2'd0, 3'd2, 1, tick_cnt); wr(3'd0, 4'd0, 4'd7, 4'd6, 4'd0, 1'b1);
    expect_ev(0, 0, 2'd0, 3'd2, 1, tick_cnt); wr(3'd0, 4'd3, 4'd0, 4'd0, 4'd0, 1'b1);
    expect_ev(0, 0, 2'd0, 3'd2, 1, tick_cnt); wr(3'd0, 4'd0, 4'd6, 4'd1, 4'd10, 1'b1);
    tick_at(4'd0, 4'd0, 4'd0, 4'd0);
    expect_ev(1, 0, 2'd0, 3'd0, 0, tick_cnt + 1);
    tick_at(4'd0, 4'd6, 4'd1, 4'd5);
    tick_n(2);
    expect_ev(0, 0, 2'd0, 3'd0, 0, tick_cnt);
    press(1'b1, 1'b0);

    // Three snoozes of 30 ticks each; a fourth is ignored.
    expect_ev(1, 0, 2'd0, 3'd2, 0, tick_cnt + 1);
    tick_at(4'd0, 4'd7, 4'd3, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      expect_ev(0, 1, 2'(k), 3'd2, 0, tick_cnt);
      expect_ev(1, 0, 2'(k), 3'd2, 0, tick_cnt + 30);
      press(1'b0, 1'b1);
      tick_n(30);
    end
    press(1'b0, 1'b1);
    tick_n(3);
    // Stop and snooze together: stop wins.
    expect_ev(0, 0, 2'd0, 3'd2, 0, tick_cnt);
    press(1'b1, 1'b1);

    // Slots 1 and 3 both 12:00: lowest index wins; al_on low kills the ring.
    wr(3'd1, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1);
    wr(3'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1);
    expect_ev(1, 0, 2'd0, 3'd1, 0, tick_cnt + 1);
    tick_at(4'd1, 4'd2, 4'd0, 4'd0);
    tick_n(2);
    expect_ev(0, 0, 2'd0, 3'd1, 0, tick_cnt);
    al_on = 1'b0;
    repeat (3) cyc();
    al_on = 1'b1;

    // Async reset in the middle of a snooze.
    expect_ev(1, 0, 2'd0, 3'd1, 0, tick_cnt + 1);
    tick_at(4'd1, 4'd2, 4'd0, 4'd0);
    expect_ev(0, 1, 2'd1, 3'd1, 0, tick_cnt);
    press(1'b0, 1'b1);
    tick_n(3);
    expect_ev(0, 0, 2'd0, 3'd0, 0, tick_cnt);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_alarm", 32'(alarm), 0);
    chk("async_rst_snz_act", 32'(snooze_active), 0);
    chk("async_rst_snz_cnt", 32'(snooze_cnt), 0);
    chk("async_rst_idx", 32'(active_idx), 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    tick_at(4'd1, 4'd2, 4'd0, 4'd0);
    tick_at(4'd0, 4'd0, 4'd0, 4'd0);
    wr(3'd0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1);
    expect_ev(1, 0, 2'd0, 3'd0, 0, tick_cnt + 1);
    tick_at(4'd1, 4'd2, 4'd0, 4'd0);
    expect_ev(0, 0, 2'd0, 3'd0, 0, tick_cnt);
    press(1'b1, 1'b0);

    repeat (5) cyc();
    chk("events_left", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
